// File: rtl/multicycle_controller.sv
// Control FSM for the 16-bit multicycle datapath: sequences fetch, PC increment,
// decode, execute, memory access and writeback, and drives every datapath select/strobe.
module multicycle_controller #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic             memory_ready,
    output logic             memory_request,
    output logic             memory_write_enable,
    output logic             memory_address_select,
    output logic [1:0]       alu_a_select,
    output logic             alu_b_select,
    output logic [2:0]       alu_operation,
    output logic             program_counter_write_enable,
    output logic             instruction_write_enable,
    output logic             status_write_enable,
    output logic             register_write_enable,
    output logic [2:0]       register_write_data_select,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned ASEL_W  = 2;

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_CMP   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHIFT = OP_W'(6);

    localparam logic [ASEL_W-1:0] A_PC   = ASEL_W'(0);
    localparam logic [ASEL_W-1:0] A_SRC  = ASEL_W'(1);
    localparam logic [ASEL_W-1:0] A_SEXT = ASEL_W'(2);
    localparam logic [ASEL_W-1:0] A_ZEXT = ASEL_W'(3);

    localparam logic [SEL_W-1:0] WB_ALU  = SEL_W'(0);
    localparam logic [SEL_W-1:0] WB_SRC  = SEL_W'(1);
    localparam logic [SEL_W-1:0] WB_IMM  = SEL_W'(2);
    localparam logic [SEL_W-1:0] WB_UPP  = SEL_W'(3);
    localparam logic [SEL_W-1:0] WB_MEM  = SEL_W'(4);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 3'd0,
        S_INCREMENT = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_MEM_READ  = 3'd5,
        S_MEM_WRITE = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_CMP,
        CLS_MOVE,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } class_t;

    typedef struct packed {
        logic              request;
        logic              write;
        logic              addr_sel;
        logic [ASEL_W-1:0] alu_a;
        logic              alu_b;
        logic [OP_W-1:0]   alu_op;
        logic              pc_we;
        logic              status_we;
        logic              reg_we;
        logic              ready_reg_we;
        logic              ready_ir_we;
        logic [SEL_W-1:0]  wb_sel;
    } ctrl_t;

    state_t            state_q;
    state_t            state_d;
    state_t            target;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    logic              fault_q;

    class_t            dec_class;
    logic [OP_W-1:0]   dec_op;
    logic [ASEL_W-1:0] dec_a;
    logic              dec_status;
    logic [SEL_W-1:0]  dec_sel;

    logic [3:0]        opcode;
    logic [3:0]        ext;
    logic              unused_fields;

    assign opcode        = instruction[15:12];
    assign ext           = instruction[7:4];
    assign unused_fields = ^{instruction[11:8], instruction[3:0]};

    // Instruction decode: class plus the execute/writeback controls it implies.
    always_comb begin
        dec_class  = CLS_ILLEGAL;
        dec_op     = OP_ADD;
        dec_a      = A_PC;
        dec_status = 1'b0;
        dec_sel    = WB_ALU;
        case (opcode)
            4'b0000: begin
                case (ext)
                    4'b0101: begin dec_class = CLS_ALU; dec_op = OP_ADD; dec_a = A_SRC; dec_status = 1'b1; end
                    4'b1001: begin dec_class = CLS_ALU; dec_op = OP_SUB; dec_a = A_SRC; dec_status = 1'b1; end
                    4'b1011: begin dec_class = CLS_CMP; dec_op = OP_CMP; dec_a = A_SRC; dec_status = 1'b1; end
                    4'b0001: begin dec_class = CLS_ALU; dec_op = OP_AND; dec_a = A_SRC; end
                    4'b0010: begin dec_class = CLS_ALU; dec_op = OP_OR;  dec_a = A_SRC; end
                    4'b0011: begin dec_class = CLS_ALU; dec_op = OP_XOR; dec_a = A_SRC; end
                    4'b1101: begin dec_class = CLS_MOVE; dec_sel = WB_SRC; end
                    default: dec_class = CLS_ILLEGAL;
                endcase
            end
            4'b0101: begin dec_class = CLS_ALU; dec_op = OP_ADD; dec_a = A_SEXT; dec_status = 1'b1; end
            4'b1001: begin dec_class = CLS_ALU; dec_op = OP_SUB; dec_a = A_SEXT; dec_status = 1'b1; end
            4'b1011: begin dec_class = CLS_CMP; dec_op = OP_CMP; dec_a = A_SEXT; dec_status = 1'b1; end
            4'b0001: begin dec_class = CLS_ALU; dec_op = OP_AND; dec_a = A_ZEXT; end
            4'b0010: begin dec_class = CLS_ALU; dec_op = OP_OR;  dec_a = A_ZEXT; end
            4'b0011: begin dec_class = CLS_ALU; dec_op = OP_XOR; dec_a = A_ZEXT; end
            4'b1101: begin dec_class = CLS_MOVE; dec_sel = WB_IMM; end
            4'b1111: begin dec_class = CLS_MOVE; dec_sel = WB_UPP; end
            4'b0100: begin
                case (ext)
                    4'b0000: dec_class = CLS_LOAD;
                    4'b0100: dec_class = CLS_STORE;
                    default: dec_class = CLS_ILLEGAL;
                endcase
            end
            4'b1000: begin
                case (ext)
                    4'b0100:          begin dec_class = CLS_ALU; dec_op = OP_SHIFT; dec_a = A_SRC;  end
                    4'b0000, 4'b0001: begin dec_class = CLS_ALU; dec_op = OP_SHIFT; dec_a = A_ZEXT; end
                    default:          dec_class = CLS_ILLEGAL;
                endcase
            end
            default: dec_class = CLS_ILLEGAL;
        endcase
    end

    // Next-state selection; reset overrides everything and returns to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = memory_ready ? S_INCREMENT : S_FETCH;
            S_INCREMENT: state_d = S_DECODE;
            S_DECODE: begin
                case (dec_class)
                    CLS_ALU, CLS_CMP: state_d = S_EXECUTE;
                    CLS_MOVE:         state_d = S_WRITEBACK;
                    CLS_LOAD:         state_d = S_MEM_READ;
                    CLS_STORE:        state_d = S_MEM_WRITE;
                    default:          state_d = S_FAULT;
                endcase
            end
            S_EXECUTE:   state_d = (dec_class == CLS_CMP) ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            S_MEM_READ:  state_d = memory_ready ? S_FETCH : S_MEM_READ;
            S_MEM_WRITE: state_d = memory_ready ? S_FETCH : S_MEM_WRITE;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_FETCH;
        endcase
        target = reset ? state_d : S_FETCH;
    end

    // Controls for the state being entered, so they can be registered.
    always_comb begin
        ctrl_d = '0;
        case (target)
            S_FETCH: begin
                ctrl_d.request     = 1'b1;
                ctrl_d.ready_ir_we = 1'b1;
            end
            S_INCREMENT: begin
                ctrl_d.alu_a  = A_PC;
                ctrl_d.alu_b  = 1'b1;
                ctrl_d.alu_op = OP_ADD;
                ctrl_d.pc_we  = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_d.alu_a     = dec_a;
                ctrl_d.alu_op    = dec_op;
                ctrl_d.status_we = dec_status;
            end
            // The result register re-samples every cycle, so ALU controls persist here.
            S_WRITEBACK: begin
                ctrl_d.alu_a  = dec_a;
                ctrl_d.alu_op = dec_op;
                ctrl_d.reg_we = 1'b1;
                ctrl_d.wb_sel = dec_sel;
            end
            S_MEM_READ: begin
                ctrl_d.request      = 1'b1;
                ctrl_d.addr_sel     = 1'b1;
                ctrl_d.ready_reg_we = 1'b1;
                ctrl_d.wb_sel       = WB_MEM;
            end
            S_MEM_WRITE: begin
                ctrl_d.request  = 1'b1;
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.write    = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        state_q <= target;
        ctrl_q  <= ctrl_d;
        fault_q <= (target == S_FAULT);
    end

    // Strobes and request are suppressed while reset is held low.
    assign memory_request               = ctrl_q.request & reset;
    assign memory_write_enable          = ctrl_q.write & reset;
    assign memory_address_select        = ctrl_q.addr_sel;
    assign alu_a_select                 = ctrl_q.alu_a;
    assign alu_b_select                 = ctrl_q.alu_b;
    assign alu_operation                = ctrl_q.alu_op;
    assign program_counter_write_enable = ctrl_q.pc_we & reset;
    assign instruction_write_enable     = ctrl_q.ready_ir_we & memory_ready & reset;
    assign status_write_enable          = ctrl_q.status_we & reset;
    assign register_write_enable        = (ctrl_q.reg_we | (ctrl_q.ready_reg_we & memory_ready)) & reset;
    assign register_write_data_select   = ctrl_q.wb_sel;
    assign fault                        = fault_q;
    assign state                        = state_q;

endmodule
